// File: rtl/clk_ena_gen.sv
// Clock-enable and quadrature E/Q CPU phase generator for the Dragon/CoCo core.
// Speed modes are applied only at E-cycle boundaries so no bus cycle is ever shortened.
module clk_ena_gen #(
  parameter int                         NUM_MODES = 4,
  parameter int                         MODE_W    = 2,
  parameter int                         DIV_W     = 4,
  parameter logic [NUM_MODES*DIV_W-1:0] DIVS      = {4'd3, 4'd1, 4'd2, 4'd3},
  parameter int                         PHASE_DIV = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              hold,
  output logic              clk_ena,
  output logic              clk_e,
  output logic              clk_q,
  output logic              cycle_start,
  output logic [MODE_W-1:0] mode_active,
  output logic              switch_pending
);

  localparam int               PH_W    = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam int               NSLOT   = 2 ** MODE_W;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PHASE_DIV - 1);
  localparam logic [PH_W-1:0]  Q_LO    = PH_W'(PHASE_DIV / 4);
  localparam logic [PH_W-1:0]  Q_HI    = PH_W'(3 * PHASE_DIV / 4);
  localparam logic [PH_W-1:0]  E_LO    = PH_W'(PHASE_DIV / 2);
  localparam logic [MODE_W:0]  NM      = (MODE_W + 1)'(NUM_MODES);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [PH_W-1:0]   r_ph;
  logic              r_ena;
  logic              r_e;
  logic              r_q;
  logic              r_cyc;
  logic [MODE_W-1:0] r_mode;
  logic              r_pend;

  logic [DIV_W-1:0]  w_div_m1_tab [NSLOT];
  logic [DIV_W-1:0]  w_div_m1;
  logic [MODE_W-1:0] w_req;
  logic [MODE_W-1:0] w_mode_nxt;
  logic [PH_W-1:0]   w_ph_nxt;
  logic              w_tick;
  logic              w_wrap;

  // Terminal-count table indexed by mode; a zero divisor field behaves as 1.
  for (genvar g = 0; g < NSLOT; g++) begin : g_div
    if (g < NUM_MODES) begin : g_used
      localparam logic [DIV_W-1:0] F = DIVS[g*DIV_W +: DIV_W];
      assign w_div_m1_tab[g] = (F == '0) ? '0 : F - DIV_W'(1);
    end else begin : g_unused
      assign w_div_m1_tab[g] = '0;
    end
  end

  assign w_req      = ({1'b0, mode_req} < NM) ? mode_req : '0;
  assign w_div_m1   = w_div_m1_tab[r_mode];
  assign w_tick     = (r_div_cnt >= w_div_m1);
  assign w_wrap     = w_tick && (r_ph == PH_LAST);
  assign w_ph_nxt   = !w_tick ? r_ph : (r_ph == PH_LAST) ? '0 : r_ph + PH_W'(1);
  assign w_mode_nxt = (w_wrap && !hold) ? w_req : r_mode;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_ph      <= '0;
      r_ena     <= 1'b0;
      r_e       <= 1'b0;
      r_q       <= 1'b0;
      r_cyc     <= 1'b0;
      r_mode    <= '0;
      r_pend    <= 1'b0;
    end else begin
      // Pending compares against the mode in effect after this edge, so it drops with cycle_start.
      r_pend <= (w_req != w_mode_nxt);
      if (hold) begin
        r_ena <= 1'b0;
        r_cyc <= 1'b0;
      end else begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
        r_ena     <= w_tick;
        r_cyc     <= w_wrap;
        r_ph      <= w_ph_nxt;
        r_q       <= (w_ph_nxt >= Q_LO) && (w_ph_nxt < Q_HI);
        r_e       <= (w_ph_nxt >= E_LO);
        r_mode    <= w_mode_nxt;
      end
    end
  end

  assign clk_ena        = r_ena;
  assign clk_e          = r_e;
  assign clk_q          = r_q;
  assign cycle_start    = r_cyc;
  assign mode_active    = r_mode;
  assign switch_pending = r_pend;

endmodule

// File: tb/tb_clk_ena_gen.sv
// Randomised and directed bench for clk_ena_gen against a tick-counting reference model.
module tb_clk_ena_gen;
  localparam int PD = 16;
  localparam int NM = 4;

  logic       clk = 1'b0, reset = 1'b0, hold = 1'b0;
  logic [1:0] mode_req = 2'd0, mode_req2 = 2'd3;
  logic       clk_ena, clk_e, clk_q, cycle_start, switch_pending;
  logic [1:0] mode_active;
  logic       ena2, e2, q2, cs2, pend2;
  logic [1:0] mode2;

  int tests = 0, fails = 0, cyc = 0;
  // Model: elapsed clocks since last tick, ticks since last boundary, mode in effect.
  int m_el = 0, m_tk = 0, m_mode = 0;
  bit m_ena = 0, m_cs = 0, m_pend = 0;
  int divtab[4] = '{3, 2, 1, 3};

  clk_ena_gen dut (
    .clk(clk), .reset(reset), .mode_req(mode_req), .hold(hold),
    .clk_ena(clk_ena), .clk_e(clk_e), .clk_q(clk_q), .cycle_start(cycle_start),
    .mode_active(mode_active), .switch_pending(switch_pending)
  );

  clk_ena_gen #(.NUM_MODES(3), .DIVS({4'd1, 4'd2, 4'd3})) dut3 (
    .clk(clk), .reset(reset), .mode_req(mode_req2), .hold(hold),
    .clk_ena(ena2), .clk_e(e2), .clk_q(q2), .cycle_start(cs2),
    .mode_active(mode2), .switch_pending(pend2)
  );

  always #5 clk = ~clk;

  function automatic int san(input logic [1:0] r);
    return (int'(r) >= NM) ? 0 : int'(r);
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      m_el = 0; m_tk = 0; m_mode = 0; m_ena = 0; m_cs = 0; m_pend = 0;
    end else begin
      m_ena = 0; m_cs = 0;
      if (!hold) begin
        m_el++;
        if (m_el >= divtab[m_mode]) begin
          m_el = 0; m_ena = 1; m_tk++;
          if (m_tk == PD) begin
            m_tk = 0; m_cs = 1; m_mode = san(mode_req);
          end
        end
      end
      m_pend = (san(mode_req) != m_mode);
    end
  endfunction

  function automatic logic [6:0] exp_vec();
    logic q, e;
    q = (m_tk >= PD/4) && (m_tk < 3*PD/4);
    e = (m_tk >= PD/2);
    return {m_ena, e, q, m_cs, m_mode[1:0], m_pend};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {clk_ena, clk_e, clk_q, cycle_start, mode_active, switch_pending};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 0; hold = 1; mode_req = 2'd1;
    step(); step();
    tests++;
    if (dut_vec() !== 7'b0) begin fails++; $display("FAIL reset_state got %b exp %b", dut_vec(), 7'b0); end
    hold = 0; mode_req = 2'd0; reset = 1; cyc = 0;
  endtask

  task automatic test_startup();
    int fe = -1, fq = -1, fe_e = -1, cs1 = -1, cs2n = -1;
    for (int i = 0; i < 110; i++) begin
      step();
      tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL startup_model cyc=%0d got %b exp %b", cyc, dut_vec(), exp_vec()); end
      if (clk_ena && fe < 0) fe = cyc;
      if (clk_q && fq < 0) fq = cyc;
      if (clk_e && fe_e < 0) fe_e = cyc;
      if (cycle_start) begin if (cs1 < 0) cs1 = cyc; else if (cs2n < 0) cs2n = cyc; end
    end
    tests++; if (fe != 3)    begin fails++; $display("FAIL first_ena got %0d exp 3", fe); end
    tests++; if (fq != 12)   begin fails++; $display("FAIL q_rise got %0d exp 12", fq); end
    tests++; if (fe_e != 24) begin fails++; $display("FAIL e_rise got %0d exp 24", fe_e); end
    tests++; if (cs1 != 48)  begin fails++; $display("FAIL first_cs got %0d exp 48", cs1); end
    tests++; if (cs2n != 96) begin fails++; $display("FAIL second_cs got %0d exp 96", cs2n); end
  endtask

  task automatic test_switch1();
    bit ok = 0;
    int n = 0, eh = 0;
    for (int i = 0; i < 100 && !ok; i++) begin step(); ok = clk_e; end
    if (!ok) begin tests++; fails++; $display("FAIL sw1_wait_e timeout"); end
    mode_req = 2'd1;
    step();
    tests++;
    if (switch_pending !== 1'b1 || mode_active !== 2'd0) begin
      fails++; $display("FAIL sw1_pending got p=%b m=%0d exp p=1 m=0", switch_pending, mode_active);
    end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL sw1_model cyc=%0d got %b exp %b", cyc, dut_vec(), exp_vec()); end
      ok = cycle_start;
    end
    if (!ok) begin tests++; fails++; $display("FAIL sw1_wait_cs timeout"); end
    tests++;
    if (mode_active !== 2'd1 || switch_pending !== 1'b0) begin
      fails++; $display("FAIL sw1_applied got m=%0d p=%b exp m=1 p=0", mode_active, switch_pending);
    end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step(); n++;
      if (clk_e) eh++;
      tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL sw1_model2 cyc=%0d got %b exp %b", cyc, dut_vec(), exp_vec()); end
      ok = cycle_start;
    end
    tests++; if (n != 32)  begin fails++; $display("FAIL sw1_period got %0d exp 32", n); end
    tests++; if (eh != 16) begin fails++; $display("FAIL sw1_e_high got %0d exp 16", eh); end
  endtask

  task automatic test_switch2();
    bit ok = 0;
    int n = 0, en = 0, qr = -1, er = -1, qf = -1;
    mode_req = 2'd2;
    for (int i = 0; i < 100 && !ok; i++) begin step(); ok = cycle_start; end
    if (!ok) begin tests++; fails++; $display("FAIL sw2_wait_cs timeout"); end
    tests++;
    if (mode_active !== 2'd2) begin fails++; $display("FAIL sw2_applied got %0d exp 2", mode_active); end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step(); n++;
      if (clk_ena) en++;
      if (clk_q && qr < 0) qr = n;
      if (clk_e && er < 0) er = n;
      if (!clk_q && qr >= 0 && qf < 0) qf = n;
      tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL sw2_model cyc=%0d got %b exp %b", cyc, dut_vec(), exp_vec()); end
      ok = cycle_start;
    end
    tests++; if (n != 16)  begin fails++; $display("FAIL sw2_period got %0d exp 16", n); end
    tests++; if (en != 16) begin fails++; $display("FAIL sw2_ena_count got %0d exp 16", en); end
    tests++;
    if (qr != 4 || er != 8 || qf != 12) begin
      fails++; $display("FAIL sw2_quadrature got q^%0d e^%0d qv%0d exp 4 8 12", qr, er, qf);
    end
  endtask

  task automatic test_toggle();
    bit ok = 0;
    int n = 0;
    mode_req = 2'd0;
    for (int i = 0; i < 100 && !ok; i++) begin step(); ok = cycle_start; end
    if (!ok) begin tests++; fails++; $display("FAIL tog_wait_cs timeout"); end
    tests++;
    if (mode_active !== 2'd0) begin fails++; $display("FAIL tog_back0 got %0d exp 0", mode_active); end
    step(); step(); n = 2;
    mode_req = 2'd1;
    step(); n++;
    tests++; if (switch_pending !== 1'b1) begin fails++; $display("FAIL tog_pend_set got %b exp 1", switch_pending); end
    step(); n++;
    mode_req = 2'd0;
    step(); n++;
    tests++; if (switch_pending !== 1'b0) begin fails++; $display("FAIL tog_pend_clr got %b exp 0", switch_pending); end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin step(); n++; ok = cycle_start; end
    tests++; if (n != 48) begin fails++; $display("FAIL tog_period got %0d exp 48", n); end
    tests++; if (mode_active !== 2'd0) begin fails++; $display("FAIL tog_mode got %0d exp 0", mode_active); end
  endtask

  task automatic test_hold();
    bit ok = 0;
    int n = 0;
    logic [1:0] eq;
    for (int i = 0; i < 200 && !ok; i++) begin step(); ok = (m_el == 1 && m_tk == 5); end
    if (!ok) begin tests++; fails++; $display("FAIL hold_wait timeout"); end
    eq = {clk_e, clk_q};
    hold = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (clk_ena !== 1'b0 || cycle_start !== 1'b0 || {clk_e, clk_q} !== eq || dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL hold_frozen cyc=%0d got %b exp %b", cyc, dut_vec(), exp_vec());
      end
    end
    hold = 0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin step(); n++; ok = clk_ena; end
    tests++; if (n != 2) begin fails++; $display("FAIL hold_resume got %0d exp 2", n); end
    tests++;
    if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL hold_after got %b exp %b", dut_vec(), exp_vec()); end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin step(); ok = (m_el == 2 && m_tk == PD - 1); end
    if (!ok) begin tests++; fails++; $display("FAIL hold_bnd_wait timeout"); end
    hold = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (cycle_start !== 1'b0) begin fails++; $display("FAIL hold_bnd_defer got %b exp 0", cycle_start); end
    end
    hold = 0;
    step();
    tests++; if (cycle_start !== 1'b1) begin fails++; $display("FAIL hold_bnd_release got %b exp 1", cycle_start); end
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    int fe = -1, fq = -1, fe_e = -1, cs1 = -1;
    mode_req = 2'd1;
    for (int i = 0; i < 200 && !ok; i++) begin step(); ok = (mode_active == 2'd1 && clk_e); end
    if (!ok) begin tests++; fails++; $display("FAIL rstmid_wait timeout"); end
    reset = 0; mode_req = 2'd0;
    step();
    tests++;
    if (dut_vec() !== 7'b0) begin fails++; $display("FAIL rstmid_zero got %b exp %b", dut_vec(), 7'b0); end
    reset = 1; cyc = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (clk_ena && fe < 0) fe = cyc;
      if (clk_q && fq < 0) fq = cyc;
      if (clk_e && fe_e < 0) fe_e = cyc;
      if (cycle_start && cs1 < 0) cs1 = cyc;
    end
    tests++;
    if (fe != 3 || fq != 12 || fe_e != 24 || cs1 != 48) begin
      fails++; $display("FAIL rstmid_restart got %0d %0d %0d %0d exp 3 12 24 48", fe, fq, fe_e, cs1);
    end
  endtask

  task automatic test_num_modes();
    int en = 0;
    reset = 0; step(); reset = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ena2) en++;
      tests++;
      if (mode2 !== 2'd0 || pend2 !== 1'b0) begin
        fails++; $display("FAIL nm3_sanitise got m=%0d p=%b exp m=0 p=0", mode2, pend2);
      end
    end
    tests++; if (en != 20) begin fails++; $display("FAIL nm3_ena_count got %0d exp 20", en); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) mode_req = 2'($urandom_range(3));
      hold  = ($urandom_range(9) == 0);
      reset = ($urandom_range(299) != 0);
      step();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        if (fails < 20) $display("FAIL random_model cyc=%0d got %b exp %b", cyc, dut_vec(), exp_vec());
      end
    end
    reset = 1; hold = 0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_switch1();
    test_switch2();
    test_toggle();
    test_hold();
    test_reset_mid();
    test_num_modes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/clk_ena_gen.md
Name: clk_ena_gen

Overview:
- Parametrised clock-enable and CPU phase generator for the Dragon/CoCo core.
- Derives a pixel/SAM-rate enable pulse from the 42.954 MHz system clock, selectable from several divisor modes (normal, turbo and faster).
- Generates quadrature E/Q CPU phases from that enable.
- Mode changes take effect only at CPU cycle boundaries, so no bus cycle is ever truncated. A hold input freezes timing for halt and DMA.

Parameters:
- NUM_MODES, 4, number of selectable speed modes.
- MODE_W, 2, width of the mode select; must satisfy 2**MODE_W >= NUM_MODES.
- DIV_W, 4, width of each divisor field.
- DIVS, {4'd3,4'd1,4'd2,4'd3}, packed divisors; mode i uses DIVS[i*DIV_W +: DIV_W].
  - Default: mode0=3 (14.318 MHz), mode1=2 (21.477 MHz turbo), mode2=1, mode3=3.
- PHASE_DIV, 16, enable ticks per CPU E cycle; must be a multiple of 4 and >= 4.

Ports:
- clk  in  1  system clock, 42.954 MHz.
- reset  in  1  synchronous, active-low reset.
- mode_req  in  MODE_W  requested speed mode.
- hold  in  1  freezes all counters while high.
- clk_ena  out  1  single-cycle enable pulse at the selected rate.
- clk_e  out  1  CPU E phase.
- clk_q  out  1  CPU Q phase; leads E by a quarter cycle.
- cycle_start  out  1  one-clk pulse at the start of each E cycle (E falling).
- mode_active  out  MODE_W  mode currently in effect.
- switch_pending  out  1  mode_req differs from mode_active and the switch is not yet applied.

Behaviour:
- Reset (reset==0 sampled at a clk edge):
  - div_cnt=0, ph=0, clk_ena=0, clk_e=0, clk_q=0, cycle_start=0, mode_active=0, switch_pending=0.
- Effective divisor: div = DIVS field of mode_active.
  - A field value of 0 is treated as 1.
  - mode_active is never loaded with a value >= NUM_MODES; such a request is treated as mode 0.
- Divider, each clk with hold=0:
  - If div_cnt == div-1: div_cnt<=0, clk_ena<=1.
  - Otherwise: div_cnt<=div_cnt+1, clk_ena<=0.
  - Result: first clk_ena appears div cycles after reset release, then every div cycles.
  - div=1 gives clk_ena high continuously.
- Phase counter: on every cycle in which the registered clk_ena is high, ph <= (ph+1) mod PHASE_DIV.
- Phase outputs, registered from the next ph value so they change on the same edge as ph:
  - clk_q=1 for ph in [PHASE_DIV/4, 3*PHASE_DIV/4).
  - clk_e=1 for ph in [PHASE_DIV/2, PHASE_DIV).
  - Order within a cycle: Q rises, E rises, Q falls, E falls.
- cycle_start: pulses for one clk on the edge where ph wraps PHASE_DIV-1 -> 0. This coincides with clk_e falling.
- Mode switch:
  - switch_pending = (sanitised mode_req != mode_active), registered.
  - mode_active loads the sanitised mode_req only on the cycle_start edge. div_cnt is 0 at that edge.
  - The new divisor governs the very next divider count.
  - If mode_req changes back before the boundary, no switch occurs and switch_pending clears.
  - mode_req may change every cycle; only the value sampled at the boundary edge matters.
- Hold:
  - While hold=1: div_cnt, ph, clk_e, clk_q and mode_active are frozen; clk_ena=0; cycle_start=0.
  - On release, counting resumes from the frozen div_cnt with no lost or extra tick.
  - A boundary coinciding with hold=1 is deferred until the tick after release.
- Simultaneous reset and hold: reset wins.
- Reset mid-cycle: all outputs return to reset values on the next edge, with no partial E pulse afterwards.

Test Plan:
- Reset release, mode_req=0, hold=0 -> clk_ena pulses at cycles 3,6,9,...; clk_q rises after 4 ticks (cycle 12); clk_e rises at tick 8 (cycle 24); E period 48 clk; cycle_start at cycle 48.
- mode_req=1 asserted mid E cycle -> switch_pending=1 until the next cycle_start; mode_active=1 there; following E period 32 clk; no E high or low phase shorter than 8 ticks.
- mode_req=2 -> clk_ena constantly high after the switch; E period 16 clk; Q/E quadrature preserved.
- mode_req toggled 0->1->0 within one E cycle -> mode_active stays 0; switch_pending returns to 0; period stays 48.
- hold=1 for 10 clk at div_cnt=1, ph=5 -> no clk_ena, E/Q frozen; after release the next clk_ena arrives 2 clk later (div_cnt resumes at 1); ph continues at 6.
- reset=0 for 1 clk while clk_e=1 in mode 1 -> all outputs 0 next edge; mode_active=0; restart timing identical to the first scenario.
- mode_req=3 with NUM_MODES=3 override -> treated as 0; switch_pending stays 0 when mode_active=0.
